imm_rotate_encoder: RTL and testbench

IMM_ROTATE_ENCODER -- requirements
Module: imm_rotate_encoder

---
 rtl/arm_imm_pkg.sv | 28 ++
 rtl/imm_fit_check.sv | 21 ++
 rtl/imm_rotate_encoder.sv | 143 ++++++++++++++
 tb/tb_imm_rotate_encoder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/arm_imm_pkg.sv
// Shared definitions for ARM rotated-immediate encoding: FSM states, field widths, rotate helper.
// Optional build macro IMM_ENC_INVERT_EN adds the inverted-search state.
`default_nettype none

package arm_imm_pkg;

  localparam int ROT_W = 4;
  localparam int IMM_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_SEARCH     = 2'd1,
`ifdef IMM_ENC_INVERT_EN
    ST_SEARCH_INV = 2'd2,
`endif
    ST_RESP       = 2'd3
  } state_e;

  // Rotate left via a doubled word so a zero amount needs no special case.
  function automatic logic [31:0] rol32(input logic [31:0] value, input logic [4:0] amount);
    logic [63:0] dbl;
    dbl = {value, value} << amount;
    return dbl[63:32];
  endfunction

endpackage

`default_nettype wire

// File: rtl/imm_fit_check.sv
// Combinational test of one rotation candidate: does ROL(value, 2*rot) fit in the low byte?
`default_nettype none

module imm_fit_check
  import arm_imm_pkg::*;
(
  input  logic [31:0]      value_i,
  input  logic [ROT_W-1:0] rot_i,
  output logic             hit_o,
  output logic [IMM_W-1:0] imm8_o
);

  logic [31:0] cand;

  assign cand   = rol32(value_i, {rot_i, 1'b0});
  assign hit_o  = (cand[31:IMM_W] == '0);
  assign imm8_o = cand[IMM_W-1:0];

endmodule

`default_nettype wire

// File: rtl/imm_rotate_encoder.sv
// Sequential search for an ARM data-processing rotated-immediate encoding, one rotation per cycle.
// Build macro IMM_ENC_INVERT_EN enables a second pass on ~value (MVN/BIC form).
`default_nettype none

module imm_rotate_encoder
  import arm_imm_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_found,
  output logic        out_inverted,
  output logic [11:0] out_data12
);

  state_e           state_q;
  logic [31:0]      value_q;
  logic [ROT_W-1:0] rot_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             found_q;
  logic [11:0]      data_q;
`ifdef IMM_ENC_INVERT_EN
  logic             inverted_q;
`endif

  logic [31:0]      fit_value;
  logic             fit_hit;
  logic [IMM_W-1:0] fit_imm;

`ifdef IMM_ENC_INVERT_EN
  assign fit_value = (state_q == ST_SEARCH_INV) ? ~value_q : value_q;
`else
  assign fit_value = value_q;
`endif

  imm_fit_check u_fit (
    .value_i (fit_value),
    .rot_i   (rot_q),
    .hit_o   (fit_hit),
    .imm8_o  (fit_imm)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      value_q     <= '0;
      rot_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      found_q     <= 1'b0;
      data_q      <= '0;
`ifdef IMM_ENC_INVERT_EN
      inverted_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            value_q    <= in_value;
            rot_q      <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ST_SEARCH;
          end else begin
            in_ready_q <= 1'b1;
          end
        end

        ST_SEARCH: begin
          if (fit_hit) begin
            found_q <= 1'b1;
            data_q  <= {rot_q, fit_imm};
            state_q <= ST_RESP;
          end else if (rot_q == '1) begin
`ifdef IMM_ENC_INVERT_EN
            rot_q   <= '0;
            state_q <= ST_SEARCH_INV;
`else
            found_q <= 1'b0;
            data_q  <= '0;
            state_q <= ST_RESP;
`endif
          end else begin
            rot_q <= rot_q + 1'b1;
          end
        end

`ifdef IMM_ENC_INVERT_EN
        ST_SEARCH_INV: begin
          if (fit_hit) begin
            found_q    <= 1'b1;
            inverted_q <= 1'b1;
            data_q     <= {rot_q, fit_imm};
            state_q    <= ST_RESP;
          end else if (rot_q == '1) begin
            found_q    <= 1'b0;
            inverted_q <= 1'b0;
            data_q     <= '0;
            state_q    <= ST_RESP;
          end else begin
            rot_q <= rot_q + 1'b1;
          end
        end
`endif

        // The first RESP cycle only raises out_valid; the result is already latched.
        ST_RESP: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            found_q     <= 1'b0;
            data_q      <= '0;
`ifdef IMM_ENC_INVERT_EN
            inverted_q  <= 1'b0;
`endif
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_found  = found_q;
  assign out_data12 = data_q;
`ifdef IMM_ENC_INVERT_EN
  assign out_inverted = inverted_q;
`else
  assign out_inverted = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_imm_rotate_encoder.sv
// Directed self-checking bench for imm_rotate_encoder; expectations follow IMM_ENC_INVERT_EN.
`default_nettype none
`timescale 1ns/1ps

module tb_imm_rotate_encoder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_value = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_found;
  logic        out_inverted;
  logic [11:0] out_data12;

  int checks = 0;
  int errors = 0;

  imm_rotate_encoder dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_value     (in_value),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_found    (out_found),
    .out_inverted (out_inverted),
    .out_data12   (out_data12)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Drives one request and measures edges from the accepting edge to out_valid.
  task automatic send_req(input logic [31:0] v, output int lat);
    int w;
    lat = -1;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (in_ready) begin
      in_valid = 1'b1;
      in_value = v;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_value = ~v ^ 32'h5A5A_0F0F;
      for (int i = 1; i <= 40; i++) begin
        @(posedge clk);
        #1;
        if (out_valid === 1'b1) begin
          lat = i;
          break;
        end
      end
    end
  endtask

  task automatic test_encode(input string name, input logic [31:0] v, input logic exp_found,
                             input logic exp_inv, input logic [11:0] exp_data, input int exp_lat);
    int lat;
    send_req(v, lat);
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (out_found !== exp_found) begin
      errors++;
      $display("FAIL %s found: got %b expected %b", name, out_found, exp_found);
    end
    checks++;
    if (out_inverted !== exp_inv) begin
      errors++;
      $display("FAIL %s inverted: got %b expected %b", name, out_inverted, exp_inv);
    end
    checks++;
    if (out_data12 !== exp_data) begin
      errors++;
      $display("FAIL %s data12: got %03h expected %03h", name, out_data12, exp_data);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s release: out_valid=%b in_ready=%b expected 0/1", name, out_valid, in_ready);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_found, out_inverted, out_data12} !== 16'h0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b %b %b %b %03h expected all zero",
               in_ready, out_valid, out_found, out_inverted, out_data12);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int exp_lat;
`ifdef IMM_ENC_INVERT_EN
    exp_lat = 33;
`else
    exp_lat = 17;
`endif
    send_req(32'h0000_0101, lat);
    checks++;
    if (lat != exp_lat || out_found !== 1'b0 || out_data12 !== 12'h000 || out_inverted !== 1'b0) begin
      errors++;
      $display("FAIL bp_result: lat=%0d found=%b inv=%b data=%03h expected %0d/0/0/000",
               lat, out_found, out_inverted, out_data12, exp_lat);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_value = 32'h0000_00FF;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_found !== 1'b0 || out_data12 !== 12'h000) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b ready=%b found=%b data=%03h expected 1/0/0/000",
                 c, out_valid, in_ready, out_found, out_data12);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_ignored_req: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid_search();
    bit stale;
    @(negedge clk);
    in_valid = 1'b1;
    in_value = 32'h0000_0101;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_found, out_inverted, out_data12} !== 16'h0000) begin
      errors++;
      $display("FAIL mid_reset_outputs: got %b %b %b %b %03h expected all zero",
               in_ready, out_valid, out_found, out_inverted, out_data12);
    end
    @(negedge clk);
    reset = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    checks++;
    if (stale || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_recovery: stale_valid=%b in_ready=%b expected 0/1", stale, in_ready);
    end
    test_encode("post_reset_3fc", 32'h0000_03FC, 1'b1, 1'b0, 12'hFFF, 17);
  endtask

  initial begin
    test_reset();
    test_encode("ff",       32'h0000_00FF, 1'b1, 1'b0, 12'h0FF, 2);
    test_encode("zero",     32'h0000_0000, 1'b1, 1'b0, 12'h000, 2);
    test_encode("ff000000", 32'hFF00_0000, 1'b1, 1'b0, 12'h4FF, 6);
    test_encode("104",      32'h0000_0104, 1'b1, 1'b0, 12'hF41, 17);
    test_encode("3fc0",     32'h0000_3FC0, 1'b1, 1'b0, 12'hDFF, 15);
`ifdef IMM_ENC_INVERT_EN
    test_encode("ffffff00", 32'hFFFF_FF00, 1'b1, 1'b1, 12'h0FF, 18);
    test_encode("00ffffff", 32'h00FF_FFFF, 1'b1, 1'b1, 12'h4FF, 22);
`else
    test_encode("ffffff00", 32'hFFFF_FF00, 1'b0, 1'b0, 12'h000, 17);
    test_encode("00ffffff", 32'h00FF_FFFF, 1'b0, 1'b0, 12'h000, 17);
`endif
    test_backpressure();
    test_reset_mid_search();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
